keypad_calc_ctrl: RTL and testbench

//  Synchronous, parametrised keypad calculator controller. Accepts decoded key strobes from the keypad

---
 rtl/calc_pkg.sv | 33 +++
 rtl/calc_bin2bcd.sv | 70 +++++++
 rtl/keypad_calc_ctrl.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_keypad_calc_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the keypad calculator controller.
//   - key codes delivered by the keypad decoder
//   - controller state and operator encodings
//   - BCD glyph codes understood by the seven-segment driver
//   - pow10() helper for elaborating decimal range limits
package calc_pkg;

  localparam logic [7:0] KEY_ADD = 8'hF0;
  localparam logic [7:0] KEY_SUB = 8'hF1;
  localparam logic [7:0] KEY_MUL = 8'hF2;
  localparam logic [7:0] KEY_DIV = 8'hF3;
  localparam logic [7:0] KEY_EQU = 8'hE0;
  localparam logic [7:0] KEY_CLR = 8'hC0;

  localparam logic [3:0] GLYPH_MINUS = 4'hA;
  localparam logic [3:0] GLYPH_E     = 4'hE;

  typedef enum logic [2:0] {
    ST_IDLE, ST_OPA, ST_OPSEL, ST_OPB, ST_CONV, ST_RESULT, ST_ERROR
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV
  } op_e;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// calc_bin2bcd: serial shift-add-3 (double-dabble) binary to BCD converter.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   start_i  in   load bin_i and begin; the first shift happens on this edge
//   bin_i    in   IN_W-bit unsigned value
//   bcd_o    out  DIGITS BCD digits, digit0 = LSBs; holds until next start
//   done_o   out  one-cycle pulse, IN_W-1 cycles after start, when bcd_o is final
// Values needing more than DIGITS digits are truncated; the caller range-checks.
module calc_bin2bcd #(
  parameter int IN_W   = 14,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [IN_W-1:0]     bin_i,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic                done_o
);

  localparam int CNT_W = $clog2(IN_W + 1);

  logic [IN_W-1:0]     sh_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] adj;
  logic [CNT_W-1:0]    cnt_q;
  logic                run_q;
  logic                done_q;

  // Add 3 to every digit >= 5 so the following left shift carries correctly.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                          : bcd_q[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        // BCD starts at zero, so no adjust is needed before the first shift.
        sh_q  <= bin_i << 1;
        bcd_q <= (4*DIGITS)'(bin_i[IN_W-1]);
        cnt_q <= CNT_W'(IN_W - 1);
        run_q <= 1'b1;
      end else if (run_q) begin
        bcd_q <= {adj[4*DIGITS-2:0], sh_q[IN_W-1]};
        sh_q  <= sh_q << 1;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = done_q;

endmodule

// File: rtl/keypad_calc_ctrl.sv
// keypad_calc_ctrl: keypad calculator controller. Collects two decimal operands and
// an operator from key strobes, computes on '=', converts to BCD and drives the display.
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   key_valid   in   one-cycle key strobe
//   key_code    in   digit 00-09, F0 add, F1 sub, F2 mul, F3 div, E0 equals, C0 clear
//   disp_bcd    out  DISP_DIGITS BCD digits, digit0 = LSBs
//   disp_blank  out  per-digit blanking, 1 = off
//   neg         out  displayed result is negative
//   err         out  error state, display shows all 'E'
//   busy        out  conversion running; keys other than clear are ignored
// Build option: define CALC_DIV_EN to enable integer divide on key F3; otherwise F3
// is ignored everywhere and no divider is built.
module keypad_calc_ctrl
  import calc_pkg::*;
#(
  parameter int N_DIGITS    = 2,
  parameter int DISP_DIGITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [7:0]               key_code,
  output logic [4*DISP_DIGITS-1:0] disp_bcd,
  output logic [DISP_DIGITS-1:0]   disp_blank,
  output logic                     neg,
  output logic                     err,
  output logic                     busy
);

  localparam int          OPND_W    = $clog2(pow10(N_DIGITS));
  localparam int          RES_W     = 2 * OPND_W;
  localparam int          CNT_W     = $clog2(N_DIGITS + 1);
  localparam int          DW        = 4 * DISP_DIGITS;
  localparam int          OW        = 4 * N_DIGITS;
  localparam int unsigned LIM_POS   = pow10(DISP_DIGITS);
  localparam int unsigned LIM_NEG   = pow10(DISP_DIGITS - 1);
  localparam int unsigned LIM_CHAIN = pow10(N_DIGITS);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [OPND_W-1:0]   a_q, a_d, b_q, b_d;
  logic [OW-1:0]       a_bcd_q, a_bcd_d, b_bcd_q, b_bcd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cstart_q, cstart_d;
  logic [RES_W-1:0]    r_q;
  logic                rneg_q, rbad_q;
  logic [DW-1:0]       disp_bcd_q, disp_bcd_d;
  logic [DISP_DIGITS-1:0] disp_blank_q, disp_blank_d;
  logic                neg_q, neg_d, err_q, err_d, busy_q;

  logic                accept, is_digit, is_op, is_equ, is_clr, key_is_op, start;
  logic [3:0]          key_digit;
  op_e                 key_op;
  logic [RES_W:0]      diff;
  logic [RES_W-1:0]    calc_mag;
  logic                calc_neg, calc_bad;
  logic [DW-1:0]       bcd_w, fmt_src, fmt_bcd;
  logic [DISP_DIGITS-1:0] fmt_blank;
  logic                fmt_neg, seen, done_w;

  // ---------------- key decode ----------------
  assign accept    = key_valid && (!busy_q || key_code == KEY_CLR);
  assign key_digit = key_code[3:0];
  assign is_digit  = accept && (key_code <= 8'h09);
  assign is_equ    = accept && (key_code == KEY_EQU);
  assign is_clr    = accept && (key_code == KEY_CLR);
  assign is_op     = accept && key_is_op;

  always_comb begin
    key_is_op = 1'b0;
    key_op    = OP_ADD;
    case (key_code)
      KEY_ADD: begin key_is_op = 1'b1; key_op = OP_ADD; end
      KEY_SUB: begin key_is_op = 1'b1; key_op = OP_SUB; end
      KEY_MUL: begin key_is_op = 1'b1; key_op = OP_MUL; end
`ifdef CALC_DIV_EN
      KEY_DIV: begin key_is_op = 1'b1; key_op = OP_DIV; end
`endif
      default: ;
    endcase
  end

  // ---------------- arithmetic (sampled on the first CONV cycle) ----------------
  always_comb begin
    calc_mag = '0;
    calc_neg = 1'b0;
    calc_bad = 1'b0;
    // Operands are far narrower than RES_W, so the top bit is a clean borrow flag.
    diff = (RES_W+1)'(a_q) - (RES_W+1)'(b_q);
    case (op_q)
      OP_ADD: calc_mag = RES_W'(a_q) + RES_W'(b_q);
      OP_SUB: begin
        calc_neg = diff[RES_W];
        calc_mag = diff[RES_W] ? RES_W'(-diff) : diff[RES_W-1:0];
      end
      OP_MUL: calc_mag = RES_W'(a_q) * RES_W'(b_q);
`ifdef CALC_DIV_EN
      OP_DIV: begin
        if (b_q == '0) calc_bad = 1'b1;
        else           calc_mag = RES_W'(a_q / b_q);
      end
`endif
      default: ;
    endcase
    // A negative result needs one display digit for the minus sign.
    if (calc_neg) calc_bad = calc_bad | (32'(calc_mag) >= LIM_NEG);
    else          calc_bad = calc_bad | (32'(calc_mag) >= LIM_POS);
  end

  calc_bin2bcd #(.IN_W(RES_W), .DIGITS(DISP_DIGITS)) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .bin_i   (calc_mag),
    .bcd_o   (bcd_w),
    .done_o  (done_w)
  );

  // ---------------- next state ----------------
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    a_bcd_d  = a_bcd_q;
    b_bcd_d  = b_bcd_q;
    cnt_d    = cnt_q;
    cstart_d = 1'b0;
    start    = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESULT: begin
        if (is_digit) begin
          state_d = ST_OPA;
          a_d     = OPND_W'(key_digit);
          a_bcd_d = OW'(key_digit);
          cnt_d   = CNT_W'(1);
        end else if (is_op && state_q == ST_RESULT) begin
          // Chaining reuses the result as operand A only if it fits an operand.
          if (!rneg_q && 32'(r_q) < LIM_CHAIN) begin
            state_d = ST_OPSEL;
            op_d    = key_op;
            a_d     = OPND_W'(r_q);
            a_bcd_d = bcd_w[OW-1:0];
            cnt_d   = CNT_W'(N_DIGITS);
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_OPA: begin
        if (is_digit) begin
          if (int'(cnt_q) < N_DIGITS) begin
            a_d     = OPND_W'(32'(a_q) * 32'd10 + 32'(key_digit));
            a_bcd_d = (a_bcd_q << 4) | OW'(key_digit);
            cnt_d   = cnt_q + 1'b1;
          end
        end else if (is_op) begin
          state_d = ST_OPSEL;
          op_d    = key_op;
        end
      end
      ST_OPSEL: begin
        if (is_digit) begin
          state_d = ST_OPB;
          b_d     = OPND_W'(key_digit);
          b_bcd_d = OW'(key_digit);
          cnt_d   = CNT_W'(1);
        end else if (is_op) begin
          op_d = key_op;
        end
      end
      ST_OPB: begin
        if (is_digit) begin
          if (int'(cnt_q) < N_DIGITS) begin
            b_d     = OPND_W'(32'(b_q) * 32'd10 + 32'(key_digit));
            b_bcd_d = (b_bcd_q << 4) | OW'(key_digit);
            cnt_d   = cnt_q + 1'b1;
          end
        end else if (is_equ) begin
          state_d  = ST_CONV;
          cstart_d = 1'b1;
        end
      end
      ST_CONV: begin
        if (cstart_q)    start   = 1'b1;
        else if (done_w) state_d = rbad_q ? ST_ERROR : ST_RESULT;
      end
      default: ;
    endcase
    if (is_clr) begin
      state_d  = ST_IDLE;
      op_d     = OP_ADD;
      a_d      = '0;
      b_d      = '0;
      a_bcd_d  = '0;
      b_bcd_d  = '0;
      cnt_d    = '0;
      cstart_d = 1'b0;
      start    = 1'b0;
    end
  end

  // ---------------- display formatting, driven from the next state ----------------
  always_comb begin
    fmt_src = '0;
    fmt_neg = 1'b0;
    case (state_d)
      ST_OPA, ST_OPSEL: fmt_src = DW'(a_bcd_d);
      ST_OPB:           fmt_src = DW'(b_bcd_d);
      ST_RESULT: begin
        fmt_src = bcd_w;
        fmt_neg = rneg_q;
      end
      default: ;
    endcase
    // Blank leading zeros (digit0 always shown) and place '-' just left of the MSD.
    fmt_bcd   = fmt_src;
    fmt_blank = '1;
    seen      = 1'b0;
    for (int i = DISP_DIGITS - 1; i >= 0; i--) begin
      if (!seen && (fmt_src[4*i +: 4] != 4'd0 || i == 0)) begin
        seen = 1'b1;
        if (fmt_neg && i < DISP_DIGITS - 1) begin
          fmt_bcd[4*(i+1) +: 4] = GLYPH_MINUS;
          fmt_blank[i+1]        = 1'b0;
        end
      end
      if (seen) fmt_blank[i] = 1'b0;
    end

    disp_bcd_d   = fmt_bcd;
    disp_blank_d = fmt_blank;
    neg_d        = fmt_neg;
    err_d        = 1'b0;
    if (state_d == ST_CONV) begin
      disp_bcd_d   = disp_bcd_q;
      disp_blank_d = disp_blank_q;
      neg_d        = neg_q;
    end else if (state_d == ST_ERROR) begin
      disp_bcd_d   = {DISP_DIGITS{GLYPH_E}};
      disp_blank_d = '0;
      neg_d        = 1'b0;
      err_d        = 1'b1;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      a_bcd_q      <= '0;
      b_bcd_q      <= '0;
      cnt_q        <= '0;
      cstart_q     <= 1'b0;
      r_q          <= '0;
      rneg_q       <= 1'b0;
      rbad_q       <= 1'b0;
      disp_bcd_q   <= '0;
      disp_blank_q <= {{(DISP_DIGITS-1){1'b1}}, 1'b0};
      neg_q        <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      a_bcd_q      <= a_bcd_d;
      b_bcd_q      <= b_bcd_d;
      cnt_q        <= cnt_d;
      cstart_q     <= cstart_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_blank_q <= disp_blank_d;
      neg_q        <= neg_d;
      err_q        <= err_d;
      busy_q       <= (state_d == ST_CONV);
      if (start) begin
        r_q    <= calc_mag;
        rneg_q <= calc_neg;
        rbad_q <= calc_bad;
      end
    end
  end

  assign disp_bcd   = disp_bcd_q;
  assign disp_blank = disp_blank_q;
  assign neg        = neg_q;
  assign err        = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_keypad_calc_ctrl.sv
`timescale 1ns/1ps
module tb_keypad_calc_ctrl;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [7:0]  key_code;
  logic [15:0] disp_bcd;
  logic [3:0]  disp_blank;
  logic        neg, err, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  keypad_calc_ctrl #(.N_DIGITS(2), .DISP_DIGITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .disp_bcd   (disp_bcd),
    .disp_blank (disp_blank),
    .neg        (neg),
    .err        (err),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected right-aligned display for value v (negative when n).
  function automatic logic [15:0] exp_bcd(input int v, input bit n);
    logic [15:0] r;
    int nd, t, p;
    r = '0; nd = 1; t = v; p = 1;
    while (t >= 10) begin nd++; t = t / 10; end
    for (int i = 0; i < 4; i++) begin
      if (i < nd) r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    if (n) r[4*nd +: 4] = 4'hA;
    return r;
  endfunction

  function automatic logic [3:0] exp_blank(input int v, input bit n);
    logic [3:0] r;
    int nd, t;
    nd = 1; t = v;
    while (t >= 10) begin nd++; t = t / 10; end
    for (int i = 0; i < 4; i++) r[i] = !(i < nd || (n && i == nd));
    return r;
  endfunction

  task automatic check_disp(input string tag, input int v, input bit n);
    check({tag, "_bcd"},   32'(disp_bcd),   32'(exp_bcd(v, n)));
    check({tag, "_blank"}, 32'(disp_blank), 32'(exp_blank(v, n)));
    check({tag, "_neg"},   32'(neg),        32'(n));
  endtask

  task automatic press(input logic [7:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_code  = 8'h00;
    $display("key %h : disp=%h blank=%b neg=%b err=%b busy=%b", c, disp_bcd, disp_blank, neg, err, busy);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called right after the '=' strobe: counts cycles until busy drops.
  task automatic wait_conv(input string tag, input int expected);
    int n;
    n = 0;
    check({tag, "_busy_set"}, 32'(busy), 32'd1);
    while (busy && n < 40) begin @(posedge clk); #1; n++; end
    check({tag, "_busy_cycles"}, 32'(n), 32'(expected));
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_disp("reset", 0, 0);
    check("reset_err",  32'(err),  32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // '=' and an operator in IDLE do nothing
    press(KEY_EQU); press(KEY_ADD);
    check("idle_equ_busy", 32'(busy), 32'd0);
    check_disp("idle_keys", 0, 0);

    // 12 + 34 = 46
    press(8'h01); check_disp("a1", 1, 0);
    press(8'h02); check_disp("a12", 12, 0);
    press(KEY_ADD); check_disp("opsel12", 12, 0);
    press(8'h03); press(8'h04); check_disp("b34", 34, 0);
    press(KEY_EQU); check_disp("conv_hold", 34, 0);
    wait_conv("add", 15);
    check_disp("r46", 46, 0);
    check("r46_err", 32'(err), 32'd0);

    // 05 - 20 = -15, then chaining a negative result is an error
    press(KEY_CLR); check_disp("clr1", 0, 0);
    press(8'h00); press(8'h05); press(KEY_SUB); press(8'h02); press(8'h00);
    check_disp("b20", 20, 0);
    press(KEY_EQU); wait_conv("sub", 15);
    check_disp("r_m15", 15, 1);
    press(KEY_ADD);
    check("negchain_err", 32'(err), 32'd1);
    check("negchain_bcd", 32'(disp_bcd), 32'h0000EEEE);
    check("negchain_blank", 32'(disp_blank), 32'd0);
    press(8'h05);
    check("err_sticky", 32'(err), 32'd1);
    press(KEY_CLR); check_disp("clr2", 0, 0);
    check("clr2_err", 32'(err), 32'd0);

    // 99 * 99 = 9801
    press(8'h09); press(8'h09); press(KEY_MUL); press(8'h09); press(8'h09);
    press(KEY_EQU); wait_conv("mul", 15);
    check_disp("r9801", 9801, 0);
    press(KEY_CLR);

    // third digit of A ignored
    press(8'h01); press(8'h02); press(8'h03);
    check_disp("a_full", 12, 0);
`ifdef CALC_DIV_EN
    press(KEY_CLR);
    press(8'h08); press(KEY_DIV); press(8'h00); press(KEY_EQU); wait_conv("div0", 15);
    check("div0_err", 32'(err), 32'd1);
    press(KEY_CLR);
    press(8'h09); press(KEY_DIV); press(8'h02); press(KEY_EQU); wait_conv("div", 15);
    check_disp("r4", 4, 0);
`else
    // F3 ignored: still in OPA, so the next op/digit gives 12 + 5
    press(KEY_DIV); check_disp("f3_ign", 12, 0);
    press(KEY_ADD); press(8'h05); check_disp("f3_b5", 5, 0);
    press(KEY_EQU); wait_conv("f3add", 15);
    check_disp("r17", 17, 0);
`endif
    press(KEY_CLR);

    // 4 + 5 = 9, chained * 3 = 27, then a digit starts fresh
    press(8'h04); press(KEY_ADD); press(8'h05); press(KEY_EQU); wait_conv("c1", 15);
    check_disp("r9", 9, 0);
    press(KEY_MUL); check_disp("chain_a9", 9, 0);
    press(8'h03); press(KEY_EQU); wait_conv("c2", 15);
    check_disp("r27", 27, 0);
    press(8'h07); check_disp("fresh7", 7, 0);
    press(KEY_CLR);

    // keys during busy are ignored (2*3 with a stray 9 mid-conversion)
    press(8'h02); press(KEY_MUL); press(8'h03); press(KEY_EQU);
    press(8'h09); wait_conv("busyign", 14);
    check_disp("r6", 6, 0);
    press(KEY_CLR);

    // clear during busy
    press(8'h01); press(KEY_ADD); press(8'h01); press(KEY_EQU);
    step(3);
    press(KEY_CLR);
    check("clrbusy_busy", 32'(busy), 32'd0);
    check_disp("clrbusy", 0, 0);
    step(20);
    check("clrbusy_later", 32'(busy), 32'd0);
    check_disp("clrbusy_later", 0, 0);

    // reset during conversion
    press(8'h02); press(KEY_MUL); press(8'h03); press(KEY_EQU);
    step(2);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    check("rstconv_busy", 32'(busy), 32'd0);
    check("rstconv_err",  32'(err),  32'd0);
    check_disp("rstconv", 0, 0);
    step(20);
    check("rstconv_later", 32'(busy), 32'd0);
    press(8'h05); check_disp("after_rst5", 5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
